bram_port_arbiter: RTL

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter sharing a single BRAM port between the host loader (0)
// and the matrix-vector PE controller (1), with round-robin ties and burst limiting.
module bram_port_arbiter #(
   parameter int MAX_BURST = 64,
   parameter int AW        = 32
) (
   input  logic          aclk,
   input  logic          aresetn,
   input  logic [1:0]    req,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [31:0]   wdata0,
   input  logic [31:0]   wdata1,
   input  logic [3:0]    we0,
   input  logic [3:0]    we1,
   output logic [1:0]    gnt,
   output logic [1:0]    rdvalid,
   output logic [31:0]   rddata,
   output logic [AW-1:0] BRAM_ADDR,
   output logic [31:0]   BRAM_WRDATA,
   output logic [3:0]    BRAM_WE,
   input  logic [31:0]   BRAM_RDDATA,
   output logic [1:0]    dbg_state
);

   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          last, last_nxt;
   logic          access;
   logic          burst_done;
   logic          other_req;

   // Handshake: an access happens in any cycle where the registered grant for
   // requester x and req[x] are both high; there is no backpressure beyond gnt.
   assign access     = (gnt[0] & req[0]) | (gnt[1] & req[1]);
   assign burst_done = access && (cnt == CW'(MAX_BURST - 1));
   assign other_req  = gnt[0] ? req[1] : req[0];

   assign BRAM_ADDR   = access ? (gnt[1] ? addr1  : addr0)  : '0;
   assign BRAM_WRDATA = access ? (gnt[1] ? wdata1 : wdata0) : '0;
   assign BRAM_WE     = access ? (gnt[1] ? we1    : we0)    : '0;
   assign rddata      = BRAM_RDDATA;
   assign dbg_state   = state;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      last_nxt  = last;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (req == 2'b01 || (req == 2'b11 && last)) begin
               state_nxt = OWN0;
               last_nxt  = 1'b0;
            end else if (req[1]) begin
               state_nxt = OWN1;
               last_nxt  = 1'b1;
            end
         end
         OWN0, OWN1: begin
            if (!access) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (burst_done) begin
               // Yield only if the other side is waiting; otherwise start a fresh burst.
               cnt_nxt = '0;
               if (other_req) state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state   <= IDLE;
         gnt     <= 2'b00;
         rdvalid <= 2'b00;
         cnt     <= '0;
         last    <= 1'b1;
      end else begin
         state   <= state_nxt;
         gnt     <= {state_nxt == OWN1, state_nxt == OWN0};
         cnt     <= cnt_nxt;
         last    <= last_nxt;
         rdvalid <= (access && BRAM_WE == 4'h0) ? gnt : 2'b00;
      end
   end

endmodule
